// File: rtl/serial_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_bridge_pkg
// Brief    : Shared state encoding and command constants for serial_reg_bridge.
//            The ACK state exists only when SERIAL_BRIDGE_ACK_EN is defined.
// Revision : 1.0
// ============================================================================
package serial_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE  = 8'h06;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ADDR = 3'd1,
        W_DATA = 3'd2,
        R_ADDR = 3'd3,
        R_WAIT = 3'd4,
        SEND   = 3'd5
`ifdef SERIAL_BRIDGE_ACK_EN
        ,
        ACK    = 3'd6
`endif
    } state_t;

    // States in which the host is mid-frame and the inter-byte timeout runs.
    function automatic logic frame_active(input state_t s);
        return (s == W_ADDR) || (s == W_DATA) || (s == R_ADDR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_reg_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_reg_bridge_if
// Brief    : UART byte stream plus 8-bit register bus of the serial bridge.
// Revision : 1.0
// ============================================================================
interface serial_reg_bridge_if;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       cmd_err;

    modport master (
        input  rx_data, new_rx_data, tx_busy, reg_rdata,
        output tx_data, new_tx_data, reg_addr, reg_wdata, reg_we, reg_re, cmd_err
    );

    modport slave (
        output rx_data, new_rx_data, tx_busy, reg_rdata,
        input  tx_data, new_tx_data, reg_addr, reg_wdata, reg_we, reg_re, cmd_err
    );
endinterface
`default_nettype wire

// File: rtl/serial_reg_bridge_frame_timeout.sv
`default_nettype none
// ============================================================================
// Module   : frame_timeout
// Brief    : Saturating idle counter; expired pulses when the count reaches
//            TIMEOUT_CYCLES-1 while enabled and not cleared.
// Revision : 1.0
// ============================================================================
module frame_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);
    localparam int              CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX   = '1;

    logic [CNT_W-1:0] r_cnt;

    // Held at zero outside a frame so every frame starts with a fresh count.
    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            r_cnt <= '0;
        end else if (r_cnt != MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = en && !clr && (r_cnt == LAST);
endmodule
`default_nettype wire

// File: rtl/serial_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : serial_reg_bridge
// Brief    : UART byte command parser driving an 8-bit register bus.
//            Define SERIAL_BRIDGE_ACK_EN to return 0x06 after every write.
// Revision : 1.0
// ============================================================================
module serial_reg_bridge
    import serial_bridge_pkg::*;
#(
    parameter int CLK_RATE       = 50000000,
    parameter int TIMEOUT_CYCLES = CLK_RATE / 100
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_reg_bridge_if.master bus
);
    state_t     r_state;
    logic [7:0] r_tx_data;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_we;
    logic       r_re;
    logic       r_err;
    logic       w_expired;
    logic       w_tx_fire;

    frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.new_rx_data),
        .en      (frame_active(r_state)),
        .expired (w_expired)
    );

    // Strobe is gated directly by tx_busy so it can never overlap a busy cycle.
    always_comb begin
        w_tx_fire = 1'b0;
        if (!rst && !bus.tx_busy) begin
            if (r_state == SEND) begin
                w_tx_fire = 1'b1;
            end
`ifdef SERIAL_BRIDGE_ACK_EN
            if (r_state == ACK && !r_we) begin
                w_tx_fire = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx_data <= 8'h00;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_we  <= 1'b0;
            r_re  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.new_rx_data) begin
                        if (bus.rx_data == CMD_WRITE) begin
                            r_state <= W_ADDR;
                        end else if (bus.rx_data == CMD_READ) begin
                            r_state <= R_ADDR;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                W_ADDR: begin
                    if (bus.new_rx_data) begin
                        r_addr  <= bus.rx_data;
                        r_state <= W_DATA;
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                W_DATA: begin
                    if (bus.new_rx_data) begin
                        r_wdata <= bus.rx_data;
                        r_we    <= 1'b1;
`ifdef SERIAL_BRIDGE_ACK_EN
                        r_tx_data <= ACK_BYTE;
                        r_state   <= ACK;
`else
                        r_state   <= IDLE;
`endif
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                R_ADDR: begin
                    if (bus.new_rx_data) begin
                        r_addr  <= bus.rx_data;
                        r_re    <= 1'b1;
                        r_state <= R_WAIT;
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                R_WAIT: begin
                    // Read data is valid the cycle after the reg_re pulse.
                    if (!r_re) begin
                        r_tx_data <= bus.reg_rdata;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (w_tx_fire) begin
                        r_state <= IDLE;
                    end
                end
`ifdef SERIAL_BRIDGE_ACK_EN
                ACK: begin
                    if (w_tx_fire) begin
                        r_state <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.tx_data     = r_tx_data;
    assign bus.new_tx_data = w_tx_fire;
    assign bus.reg_addr    = r_addr;
    assign bus.reg_wdata   = r_wdata;
    assign bus.reg_we      = r_we;
    assign bus.reg_re      = r_re;
    assign bus.cmd_err     = r_err;
endmodule
`default_nettype wire

// File: doc/serial_reg_bridge.md
# serial_reg_bridge

Byte-level command parser that sits directly downstream of the AVR serial receiver and upstream of its transmitter. It turns received UART bytes into single-cycle register read/write strobes on an 8-bit internal register bus, and returns read data, plus an optional write acknowledge, as bytes for transmission. It lets the host configure and inspect chip registers over the AVR USB-serial link.

## Interface
- `CLK_RATE`, 50000000: system clock frequency in Hz; used only for documentation and the derived default of `TIMEOUT_CYCLES`.
- `TIMEOUT_CYCLES`, CLK_RATE/100 (10 ms): number of idle cycles between bytes of one frame before that frame is abandoned.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte, valid when `new_rx_data` is high.
- `new_rx_data` in 1: one-cycle strobe for a received byte.
- `tx_data` out 8: byte to transmit.
- `new_tx_data` out 1: one-cycle strobe requesting transmission of `tx_data`.
- `tx_busy` in 1: the transmitter is shifting a byte. Tie to 0 if the transmitter is unavailable.
- `reg_addr` out 8: register address.
- `reg_wdata` out 8: register write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, sampled exactly 1 cycle after `reg_re`.
- `cmd_err` out 1: one-cycle pulse on an unknown command byte or a frame timeout.

## Operation
- Frames:
  - Write: 0x57 ('W'), then ADDR, then DATA.
  - Read: 0x52 ('R'), then ADDR; the bridge replies with a single DATA byte.
- States:
  - IDLE: on a byte of 0x57, go to W_ADDR. On 0x52, go to R_ADDR. On any other byte, pulse `cmd_err` and stay in IDLE.
  - W_ADDR: on a byte, latch `reg_addr` and go to W_DATA.
  - W_DATA: on a byte, latch `reg_wdata`, pulse `reg_we` in the next cycle, then go to ACK (macro on) or IDLE (macro off).
  - R_ADDR: on a byte, latch `reg_addr`, pulse `reg_re` in the next cycle, then go to R_WAIT.
  - R_WAIT: capture `reg_rdata` into `tx_data` and go to SEND.
  - SEND / ACK: wait until `tx_busy` is 0, then pulse `new_tx_data` for one cycle and go to IDLE. ACK drives 0x06.
- Timeout:
  - A counter runs in W_ADDR, W_DATA and R_ADDR and is cleared on every `new_rx_data`.
  - When the counter reaches `TIMEOUT_CYCLES`-1, pulse `cmd_err` and return to IDLE with no register access.
  - Counter width is $clog2(TIMEOUT_CYCLES); the counter saturates and never wraps.
- Bytes received in R_WAIT, SEND or ACK are dropped silently; the host must not pipeline frames.
- Reset values: every output is 0 and the state is IDLE.
- Reset mid-frame: the frame is abandoned, no strobe is issued, and any pending response is lost.

## Timing
- Write: `reg_we` asserts on the cycle after the DATA byte's `new_rx_data`, with `reg_addr`/`reg_wdata` already stable that cycle. Both hold until the next frame latches new values.
- Read:
  - `reg_re` asserts at cycle N+1, where N is the cycle of the ADDR strobe.
  - `reg_rdata` is sampled at N+2.
  - `new_tx_data` fires no earlier than N+3, and only once `tx_busy` is 0.
- `new_tx_data` never asserts in a cycle where `tx_busy` is 1. `tx_data` is stable from the strobe until the next strobe.
- `reg_we` and `reg_re` are never both high in the same cycle.
- `cmd_err` and `new_tx_data` are never both high in the same cycle.

## Configuration
- `SERIAL_BRIDGE_ACK_EN`:
  - Defined: every completed write is followed by one transmitted 0x06 byte, sent after `reg_we`.
  - Undefined: writes produce no transmission, and the ACK state and its encoding are absent.

## Structure
- A shared package `serial_bridge_pkg` holds:
  - the state enum;
  - constants `CMD_WRITE`=8'h57, `CMD_READ`=8'h52, `ACK_BYTE`=8'h06.
- One sub-module, `frame_timeout`: a saturating counter with clear/enable inputs and a `expired` pulse output. All other logic is flat in `serial_reg_bridge`.

## Test plan
- Write path: rx 0x57, 0x10, 0xA5 → `reg_we`=1 for exactly one cycle with `reg_addr`=0x10 and `reg_wdata`=0xA5. With the macro on, one `new_tx_data` carrying 0x06.
- Read path: rx 0x52, 0x22 with `reg_rdata`=0x3C at the sample cycle → `reg_re` pulse, then `new_tx_data` with `tx_data`=0x3C.
- Back-pressure: hold `tx_busy`=1 for 40 cycles during a read → `new_tx_data` fires exactly on the first cycle after `tx_busy` falls, and only once.
- Bad command: rx 0x00, then 0x57, 0x01, 0x02 → `cmd_err` pulses once for the first byte, then a normal write to 0x01 of data 0x02.
- Timeout: with `TIMEOUT_CYCLES`=16, rx 0x57, 0x05, then silence → `cmd_err` pulses 16 cycles after the last byte and no `reg_we` occurs. A following 'R' frame works normally.
- Reset mid-frame: rx 0x57, 0x05, assert `rst` for one cycle, then rx 0x77 → no `reg_we`, and `cmd_err` pulses because 0x77 is treated as a command byte.
